jt12_timer_bank: RTL



---
 rtl/jt12_timer_bank.sv | 105 ++++++++++
 1 files changed

// File: rtl/jt12_timer_bank.sv
`default_nettype none
//============================================================================
// jt12_timer_bank : NT up-counting timers with shared prescaler and wired IRQ.
// Optional counter readback port when JT12_TIMER_RDBK_EN is defined.
// Revision: 1.0
//============================================================================
module jt12_timer_bank #(
   parameter int              NT         = 2,
   parameter int              CW         = 10,
   parameter logic [NT-1:0]   PRESC_MASK = 2'b10,
   parameter int              PDIV       = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clk_en,
   input  logic               fast,
   input  logic [NT*CW-1:0]   value,
   input  logic [NT-1:0]      load,
   input  logic [NT-1:0]      en_irq,
   input  logic [NT-1:0]      clr_flag,
   output logic [NT-1:0]      flag,
   output logic [NT-1:0]      overflow,
   output logic               irq_n
`ifdef JT12_TIMER_RDBK_EN
   ,
   input  logic [(NT > 1 ? $clog2(NT) : 1)-1:0] rd_sel,
   output logic [CW-1:0]      cnt_rd
`endif
);

   localparam int c_PW = (PDIV > 1) ? $clog2(PDIV) : 1;

   logic [c_PW-1:0] r_presc;
   logic [CW-1:0]   r_cnt [NT];
   logic [NT-1:0]   r_run;
   logic [NT-1:0]   r_load_d;
   logic [NT-1:0]   w_tick;
   logic [NT-1:0]   w_rise;
   logic [NT-1:0]   w_wrap;
   logic            w_pwrap;

   assign w_pwrap = clk_en & (r_presc == c_PW'(PDIV - 1));
   assign irq_n   = ~|flag;

   // A load rising edge suppresses the wrap so the reload wins cleanly.
   always_comb begin
      w_tick = '0;
      w_rise = '0;
      w_wrap = '0;
      for (int i = 0; i < NT; i++) begin
         w_tick[i] = fast | (PRESC_MASK[i] ? w_pwrap : clk_en);
         w_rise[i] = load[i] & ~r_load_d[i];
         w_wrap[i] = load[i] & ~w_rise[i] & r_run[i] & w_tick[i] & (&r_cnt[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_presc <= '0;
      else if (clk_en)
         r_presc <= r_presc + c_PW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run    <= '0;
         r_load_d <= '0;
         flag     <= '0;
         overflow <= '0;
         for (int i = 0; i < NT; i++)
            r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NT; i++) begin
            r_load_d[i] <= load[i];
            overflow[i] <= w_wrap[i];
            if (!load[i]) begin
               r_run[i] <= 1'b0;
            end else if (w_rise[i]) begin
               r_cnt[i] <= value[i*CW +: CW];
               r_run[i] <= 1'b1;
            end else if (r_run[i] & w_tick[i]) begin
               r_cnt[i] <= w_wrap[i] ? value[i*CW +: CW] : r_cnt[i] + CW'(1);
            end
            // Setting has priority over a simultaneous clear.
            if (w_wrap[i] & en_irq[i])
               flag[i] <= 1'b1;
            else if (clr_flag[i])
               flag[i] <= 1'b0;
         end
      end
   end

`ifdef JT12_TIMER_RDBK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_rd <= '0;
      else if (int'(rd_sel) < NT)
         cnt_rd <= r_cnt[rd_sel];
      else
         cnt_rd <= '0;
   end
`endif

endmodule
`default_nettype wire
